pong_match_ctrl: RTL and testbench

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

---
 rtl/pong_match_ctrl_if.sv | 25 ++
 rtl/pong_match_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the pong match controller and the rest of the game.
// The slave modport is the controller side; the master modport drives inputs and observes outputs.
interface pong_match_ctrl_if;
  logic       frame_tick;
  logic [3:0] btn;
  logic       pause_btn;
  logic       miss_l;
  logic       miss_r;
  logic       gra_still;
  logic [2:0] state;
  logic [7:0] score_l;
  logic [7:0] score_r;
  logic [1:0] winner;
  logic       serve_side;

  modport slave (
    input  frame_tick, btn, pause_btn, miss_l, miss_r,
    output gra_still, state, score_l, score_r, winner, serve_side
  );

  modport master (
    output frame_tick, btn, pause_btn, miss_l, miss_r,
    input  gra_still, state, score_l, score_r, winner, serve_side
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match controller: BCD scoring, serve/game-over frame delays, winner detection.
// Optional pause support is built only when the PONG_PAUSE_EN macro is defined.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned OVER_FRAMES  = 120
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  pong_match_ctrl_if.slave   io_bus
);

  typedef enum logic [2:0] {
    StNewgame = 3'd0,
    StPlay    = 3'd1,
    StServe   = 3'd2,
    StOver    = 3'd3,
    StPause   = 3'd4
  } state_e;

  localparam logic [7:0] WinBcd    = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  localparam logic [7:0] ServeLoad = 8'(SERVE_FRAMES);
  localparam logic [7:0] OverLoad  = 8'(OVER_FRAMES);

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] >= 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] >= 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[7:4] = v[7:4];
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  state_e     r_state, w_state_d;
  logic [7:0] r_score_l, w_score_l_d;
  logic [7:0] r_score_r, w_score_r_d;
  logic [1:0] r_winner, w_winner_d;
  logic       r_serve_side, w_serve_side_d;
  logic [7:0] r_cnt, w_cnt_d;
  logic [7:0] w_inc_l, w_inc_r;
  logic       w_any_btn;

  assign w_inc_l   = bcd_inc(r_score_l);
  assign w_inc_r   = bcd_inc(r_score_r);
  assign w_any_btn = |io_bus.btn;

`ifdef PONG_PAUSE_EN
  logic r_pause;
  logic w_pause_rise;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) r_pause <= 1'b0;
    else       r_pause <= io_bus.pause_btn;
  end

  assign w_pause_rise = io_bus.pause_btn & ~r_pause;
`else
  logic w_pause_unused;
  assign w_pause_unused = io_bus.pause_btn;
`endif

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state      <= StNewgame;
      r_score_l    <= 8'h00;
      r_score_r    <= 8'h00;
      r_winner     <= 2'b00;
      r_serve_side <= 1'b0;
      r_cnt        <= 8'd0;
    end else begin
      r_state      <= w_state_d;
      r_score_l    <= w_score_l_d;
      r_score_r    <= w_score_r_d;
      r_winner     <= w_winner_d;
      r_serve_side <= w_serve_side_d;
      r_cnt        <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_score_l_d    = r_score_l;
    w_score_r_d    = r_score_r;
    w_winner_d     = r_winner;
    w_serve_side_d = r_serve_side;
    w_cnt_d        = r_cnt;
    unique case (r_state)
      StNewgame: begin
        w_score_l_d = 8'h00;
        w_score_r_d = 8'h00;
        w_winner_d  = 2'b00;
        if (w_any_btn) w_state_d = StPlay;
      end
      StPlay: begin
        if (io_bus.miss_l && io_bus.miss_r) begin
          // Simultaneous misses replay the point without scoring.
          w_state_d = StServe;
          w_cnt_d   = ServeLoad;
        end else if (io_bus.miss_l) begin
          w_score_r_d    = w_inc_r;
          w_serve_side_d = 1'b0;
          if (w_inc_r == WinBcd) begin
            w_state_d  = StOver;
            w_winner_d = 2'b10;
            w_cnt_d    = OverLoad;
          end else begin
            w_state_d = StServe;
            w_cnt_d   = ServeLoad;
          end
        end else if (io_bus.miss_r) begin
          w_score_l_d    = w_inc_l;
          w_serve_side_d = 1'b1;
          if (w_inc_l == WinBcd) begin
            w_state_d  = StOver;
            w_winner_d = 2'b01;
            w_cnt_d    = OverLoad;
          end else begin
            w_state_d = StServe;
            w_cnt_d   = ServeLoad;
          end
        end
`ifdef PONG_PAUSE_EN
        else if (w_pause_rise) begin
          w_state_d = StPause;
        end
`endif
      end
      StServe: begin
        if (io_bus.frame_tick && (r_cnt != 8'd0)) w_cnt_d = r_cnt - 8'd1;
        if ((r_cnt == 8'd0) && w_any_btn) w_state_d = StPlay;
      end
      StOver: begin
        if (io_bus.frame_tick && (r_cnt != 8'd0)) w_cnt_d = r_cnt - 8'd1;
        if ((r_cnt == 8'd0) && w_any_btn) begin
          w_state_d   = StNewgame;
          w_score_l_d = 8'h00;
          w_score_r_d = 8'h00;
          w_winner_d  = 2'b00;
        end
      end
`ifdef PONG_PAUSE_EN
      StPause: begin
        if (w_pause_rise) w_state_d = StPlay;
      end
`endif
      default: w_state_d = StNewgame;
    endcase
  end

  always_comb begin
    io_bus.gra_still  = (r_state != StPlay);
    io_bus.state      = r_state;
    io_bus.score_l    = r_score_l;
    io_bus.score_r    = r_score_r;
    io_bus.winner     = r_winner;
    io_bus.serve_side = r_serve_side;
  end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: a vector table for the opening rally plus hand sequences
// for the serve/over waits, win detection, BCD carry, pause and mid-match reset.
module tb_pong_match_ctrl;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  pong_match_ctrl_if bus_a ();
  pong_match_ctrl_if bus_b ();

  pong_match_ctrl dut_a (
    .clk_100MHz (clk),
    .reset      (rst),
    .io_bus     (bus_a)
  );

  pong_match_ctrl #(
    .WIN_SCORE    (12),
    .SERVE_FRAMES (1),
    .OVER_FRAMES  (1)
  ) dut_b (
    .clk_100MHz (clk),
    .reset      (rst),
    .io_bus     (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       ft;
    logic [3:0] btn;
    logic       ml;
    logic       mr;
    logic       pb;
    logic [2:0] st;
    logic [7:0] sl;
    logic [7:0] sr;
    logic [1:0] win;
    logic       ss;
    logic       still;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive_a(input logic ft, input logic [3:0] btn, input logic ml, input logic mr,
                         input logic pb);
    bus_a.frame_tick = ft;
    bus_a.btn        = btn;
    bus_a.miss_l     = ml;
    bus_a.miss_r     = mr;
    bus_a.pause_btn  = pb;
  endtask

  task automatic drive_b(input logic ft, input logic [3:0] btn, input logic mr);
    bus_b.frame_tick = ft;
    bus_b.btn        = btn;
    bus_b.miss_l     = 1'b0;
    bus_b.miss_r     = mr;
    bus_b.pause_btn  = 1'b0;
  endtask

  task automatic chk_a(input string n, input logic [2:0] st, input logic [7:0] sl,
                       input logic [7:0] sr, input logic [1:0] win, input logic ss,
                       input logic still);
    chk({n, ".state"}, 8'(bus_a.state), 8'(st));
    chk({n, ".score_l"}, bus_a.score_l, sl);
    chk({n, ".score_r"}, bus_a.score_r, sr);
    chk({n, ".winner"}, 8'(bus_a.winner), 8'(win));
    chk({n, ".serve_side"}, 8'(bus_a.serve_side), 8'(ss));
    chk({n, ".gra_still"}, 8'(bus_a.gra_still), 8'(still));
  endtask

  // Runs n frame ticks with buttons released, then presses a button to serve.
  task automatic serve_a(input int n);
    for (int i = 0; i < n; i++) begin
      drive_a(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive_a(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0);
    tick();
    drive_a(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    //              ft btn      ml mr pb  st    sl     sr     win    ss still
    vecs[0] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 8'h01, 2'b00, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h01, 2'b00, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 8'h01, 2'b00, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 4'b1000, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 8'h01, 2'b00, 1'b0, 1'b1};

    rst = 1'b1;
    drive_a(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive_b(1'b0, 4'b0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 3'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
    rst = 1'b0;

    // Opening rally: start, first miss, early serve attempts and ignored inputs.
    for (int i = 0; i < 6; i++) begin
      drive_a(vecs[i].ft, vecs[i].btn, vecs[i].ml, vecs[i].mr, vecs[i].pb);
      tick();
      chk_a($sformatf("vec%0d", i), vecs[i].st, vecs[i].sl, vecs[i].sr, vecs[i].win, vecs[i].ss,
            vecs[i].still);
    end

    // Held button must not cut the serve wait short (one tick already taken above).
    for (int i = 0; i < 59; i++) begin
      drive_a(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
      tick();
      chk("serve_wait.state", 8'(bus_a.state), 8'd2);
    end
    drive_a(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    chk("serve_done.state", 8'(bus_a.state), 8'd1);

    drive_a(1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
    tick();
    chk_a("both_miss", 3'd2, 8'h00, 8'h01, 2'b00, 1'b0, 1'b1);
    serve_a(60);
    chk("replay.state", 8'(bus_a.state), 8'd1);

    for (int k = 1; k <= 4; k++) begin
      drive_a(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
      tick();
      chk_a($sformatf("miss_r%0d", k), 3'd2, 8'(k), 8'h01, 2'b00, 1'b1, 1'b1);
      serve_a(60);
      chk($sformatf("serve%0d.state", k), 8'(bus_a.state), 8'd1);
    end

    drive_a(1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    tick();
    chk_a("win_left", 3'd3, 8'h05, 8'h01, 2'b01, 1'b1, 1'b1);

    for (int i = 0; i < 120; i++) begin
      drive_a(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk_a("over_hold", 3'd3, 8'h05, 8'h01, 2'b01, 1'b1, 1'b1);
    drive_a(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
    tick();
    chk_a("restart", 3'd0, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1);
    drive_a(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("newgame_idle.state", 8'(bus_a.state), 8'd0);

    drive_a(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
    tick();
    chk("replay_start.state", 8'(bus_a.state), 8'd1);
    drive_a(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
`ifdef PONG_PAUSE_EN
    chk_a("pause_on", 3'd4, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1);
    drive_a(1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
    tick();
    chk_a("pause_miss", 3'd4, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1);
    drive_a(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("pause_release.state", 8'(bus_a.state), 8'd4);
    drive_a(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
    tick();
    chk_a("pause_off", 3'd1, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
`else
    chk_a("pause_ignored", 3'd1, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0);
`endif
    drive_a(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset mid-rally, between edges, with a miss pending.
    drive_a(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_a("async_reset", 3'd0, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
    tick();
    chk("reset_hold.score_r", bus_a.score_r, 8'h00);
    drive_a(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // WIN_SCORE=12 instance: BCD carry past 9 and win at 12.
    drive_b(1'b0, 4'b0001, 1'b0);
    tick();
    chk("b_start.state", 8'(bus_b.state), 8'd1);
    for (int k = 1; k <= 12; k++) begin
      drive_b(1'b0, 4'b0000, 1'b1);
      tick();
      chk($sformatf("b_miss%0d.score_l", k), bus_b.score_l, {4'(k / 10), 4'(k % 10)});
      chk($sformatf("b_miss%0d.state", k), 8'(bus_b.state), (k < 12) ? 8'd2 : 8'd3);
      chk($sformatf("b_miss%0d.winner", k), 8'(bus_b.winner), (k < 12) ? 8'd0 : 8'd1);
      if (k < 12) begin
        drive_b(1'b1, 4'b0000, 1'b0);
        tick();
        drive_b(1'b0, 4'b1000, 1'b0);
        tick();
        chk($sformatf("b_serve%0d.state", k), 8'(bus_b.state), 8'd1);
      end
    end
    drive_b(1'b0, 4'b0000, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
